// File: rtl/bram_fifo_pkg.sv
// Shared types and helpers for the single-clock block-RAM FIFO.
package bram_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_t;

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/bram_sdp_fpro.sv
// Simple dual-port RAM: one write port, one read port with enable and registered output.
module bram_sdp_fpro
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DW = 13,
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned Depth = fifo_depth(AW);

    logic [DW-1:0] mem [Depth];
    logic [DW-1:0] rd_data_q;

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register reset maps onto the BRAM output-latch synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bram_fifo_sync.sv
// Single-clock BRAM FIFO with programmable almost flags, sticky errors and optional FWFT reads.
module bram_fifo_sync
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DW   = 13,
    parameter int unsigned AW   = 10,
    parameter bit          FWFT = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          almost_full,
    input  logic          rd_ack,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          almost_empty,
    input  logic [AW:0]   af_thresh,
    input  logic [AW:0]   ae_thresh,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err
);

    localparam fifo_mode_t  Mode       = FWFT ? FIFO_FWFT : FIFO_STD;
    localparam logic [AW:0] DepthCount = (AW+1)'(fifo_depth(AW));
    localparam logic [AW:0] OneCount   = (AW+1)'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          head_valid_q, head_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          wr_ok;
    logic          pop_ok;
    logic          ram_rd;
    logic          empty_int;
    logic [AW:0]   ram_words;

    // Words sitting in the RAM that have not yet been moved to rd_data.
    assign ram_words = count_q - {{AW{1'b0}}, head_valid_q};

    always_comb begin
        wr_ok        = wr_en && (count_q != DepthCount);
        empty_int    = (count_q == '0);
        pop_ok       = 1'b0;
        ram_rd       = 1'b0;
        head_valid_d = 1'b0;
        if (Mode == FIFO_FWFT) begin
            empty_int = !head_valid_q;
            pop_ok    = rd_ack && head_valid_q;
            // Only words counted before this edge are read, so a same-cycle write is never fetched.
            ram_rd    = (ram_words != '0) && (!head_valid_q || pop_ok);
            if (ram_rd) begin
                head_valid_d = 1'b1;
            end else if (pop_ok) begin
                head_valid_d = 1'b0;
            end else begin
                head_valid_d = head_valid_q;
            end
        end else begin
            pop_ok = rd_ack && (ram_words != '0);
            ram_rd = pop_ok;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ok  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = ram_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        unique case ({wr_ok, pop_ok})
            2'b10:   count_d = count_q + OneCount;
            2'b01:   count_d = count_q - OneCount;
            default: count_d = count_q;
        endcase
        // New errors take priority over a same-cycle clear.
        overflow_d  = (overflow_q && !clr_err) || (wr_en && !wr_ok);
        underflow_d = (underflow_q && !clr_err) || (rd_ack && empty_int);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    bram_sdp_fpro #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign full         = (count_q == DepthCount);
    assign empty        = empty_int;
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
